vx_axi_mem_slave: RTL and testbench
===================================

Name: vx_axi_mem_slave

Overview:
AXI4 responder (slave) with an internal word-addressed RAM. It is the opposite end of the Vortex AXI master port. It serves AW/W/B and AR/R traffic from Vortex_axi-class initiators in simulation and FPGA bring-up, where it stands in for the memory controller. It handles one transaction at a time, supports INCR bursts, and arbitrates write versus read with a round-robin scheme.

Parameters:
AXI_DATA_WIDTH, 512, data bus width in bits; must be a power of 2 and at least 32.
AXI_ADDR_WIDTH, 32, byte address width.
AXI_TID_WIDTH, 8, transaction ID width.
AXI_STROBE_WIDTH, AXI_DATA_WIDTH/8, byte-strobe width.
MEM_DEPTH_LOG2, 12, log2 of the number of RAM words.
RSP_DELAY, 4, extra response latency in cycles; used only when AXI_SLAVE_RSP_DELAY_EN is defined. Legal range 1..255.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_axi_awid  in  AXI_TID_WIDTH  write ID
s_axi_awaddr  in  AXI_ADDR_WIDTH  write byte address
s_axi_awlen  in  8  beats minus 1
s_axi_awsize  in  3  ignored; full-width beats only
s_axi_awburst  in  2  ignored; always treated as INCR
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  AXI_DATA_WIDTH  write data
s_axi_wstrb  in  AXI_STROBE_WIDTH  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bid  out  AXI_TID_WIDTH  echoed awid
s_axi_bresp  out  2  0=OKAY, 2=SLVERR
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_arid  in  AXI_TID_WIDTH  read ID
s_axi_araddr  in  AXI_ADDR_WIDTH  read byte address
s_axi_arlen  in  8  beats minus 1
s_axi_arsize, s_axi_arburst  in  3, 2  ignored
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rid  out  AXI_TID_WIDTH  echoed arid
s_axi_rdata  out  AXI_DATA_WIDTH  read data
s_axi_rresp  out  2  per-beat response
s_axi_rlast  out  1  final beat
s_axi_rvalid / s_axi_rready  out / in  1  R handshake
busy  out  1  transaction in flight

Behaviour:
- Reset values: all valid and ready outputs 0; bid, rid, bresp, rresp, rdata and rlast all 0; busy 0; priority bit = write-first; FSM in IDLE. RAM contents are not reset.
- Word index = addr >> log2(AXI_STROBE_WIDTH). A beat is out of range if the word index is at least 2^MEM_DEPTH_LOG2.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - awready = awvalid && (!arvalid || prio==write).
  - arready = arvalid && (!awvalid || prio==read).
  - awready and arready are never both 1 in the same cycle.
  - On an AW handshake: latch id, word address and len; clear beat count and error flag; go to WDATA.
  - On an AR handshake: latch id, address and len; load rdata/rresp for the first beat; go to RDATA.
- WDATA:
  - wready=1.
  - Each W handshake writes the strobed bytes of the current word, then increments the address and beat count.
  - An out-of-range beat is not written and sets the error flag.
  - A beat with count greater than len is dropped and sets the error flag.
  - A wlast handshake where count differs from len sets the error flag.
  - On wlast, go to WRESP.
  - W beats arriving before AW are not accepted (wready=0 outside WDATA).
- WRESP:
  - bvalid=1 in the cycle after the wlast handshake; bresp = SLVERR if the error flag is set, else OKAY.
  - bvalid, bid and bresp hold stable until bready.
  - On the B handshake: go to IDLE and set prio=read.
- RDATA:
  - rvalid=1 in the cycle after the AR handshake.
  - rdata = RAM word; rresp = OKAY. For an out-of-range beat, rdata=0 and rresp=SLVERR.
  - rlast=1 only when beat count == len.
  - rdata, rresp, rlast and rid hold stable while rready=0.
  - On an R handshake that is not the last beat: the next beat is presented in the following cycle with no bubble (back-to-back throughput of 1 beat per cycle).
  - On the last-beat handshake: go to IDLE and set prio=write.
- Address increment is modulo 2^AXI_ADDR_WIDTH; wrap-around past the top of RAM yields SLVERR beats.
- busy = (state != IDLE).
- Reset asserted mid-transaction: the next edge returns the FSM to IDLE, drops all valids, and discards the transaction. RAM writes already performed persist.
- RAM read and write within one transaction are to the same word in different cycles, so no read-during-write hazard exists.

Optional Feature:
AXI_SLAVE_RSP_DELAY_EN.
- Defined: a WAIT state counts RSP_DELAY cycles after the wlast handshake before bvalid rises, and after the AR handshake before the first rvalid rises. Later R beats of the burst remain back-to-back. awready and arready stay 0 throughout.
- Undefined: no WAIT state; latency is as stated in Behaviour.

Test Plan:
1. Write awaddr 0x40, awid 5, len 0, wdata 0xA5 pattern, wstrb all ones -> bvalid the cycle after wlast, bid 5, bresp 0. Then read 0x40 with arid 3 -> rvalid the cycle after AR, identical data, rlast 1, rid 3, rresp 0.
2. Write 0x80 with all ones, then write 0x80 with 0x00 data and wstrb 0x...0F -> read 0x80 returns low 4 bytes 0x00, rest 0xFF.
3. Write a 4-beat burst at 0x100, words 1..4. Read with arlen 3 while rready toggles 1,0,1,0 -> 4 beats, values 1..4 in order, data held during stalls, rlast on beat 4 only.
4. After reset, awvalid and arvalid rise in the same cycle -> AW accepted first, AR after B completes. Repeat the simultaneous request -> AR is granted first this time.
5. Write to word index 2^MEM_DEPTH_LOG2 -> bresp 2, RAM unchanged. Read of the same address -> rresp 2, rdata 0. A len-1 write with wlast on beat 1 -> bresp 2.
6. With AXI_SLAVE_RSP_DELAY_EN and RSP_DELAY=4 -> bvalid 5 cycles after wlast, and the first rvalid 5 cycles after AR. Reset asserted during RDATA -> rvalid 0 next cycle, busy 0.

Source files
------------

// File: rtl/vx_axi_mem_slave.sv
// vx_axi_mem_slave: AXI4 responder backed by a word-addressed RAM.
// Serves one INCR burst at a time and alternates write/read priority.
// Define AXI_SLAVE_RSP_DELAY_EN to insert RSP_DELAY wait cycles ahead of
// the write response and ahead of the first read beat.
`timescale 1ns/1ps

module vx_axi_mem_slave #(
    parameter int AXI_DATA_WIDTH   = 512,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_TID_WIDTH    = 8,
    parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int MEM_DEPTH_LOG2   = 12,
    parameter int RSP_DELAY        = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AXI_TID_WIDTH-1:0]    s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_STROBE_WIDTH-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_TID_WIDTH-1:0]    s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_TID_WIDTH-1:0]    s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_TID_WIDTH-1:0]    s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic                        busy
);

    localparam int OFF_W     = $clog2(AXI_STROBE_WIDTH);
    localparam int WA_W      = AXI_ADDR_WIDTH - OFF_W;
    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam logic [WA_W-1:0] WA_ONE = WA_W'(1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_SLAVE_RSP_DELAY_EN
    typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA, S_WAIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;
    localparam int unused_rsp_delay = RSP_DELAY;
`endif

    state_t state, state_n;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                      prio_rd;   // 0: write wins a tie, 1: read wins
    logic [AXI_TID_WIDTH-1:0]  id_q;
    logic [WA_W-1:0]           addr_q;
    logic [7:0]                len_q;
    logic [8:0]                cnt_q;
    logic                      err_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;
`ifdef AXI_SLAVE_RSP_DELAY_EN
    logic [7:0]                dly_q;
    logic                      dly_rd_q;
`endif

    logic [WA_W-1:0]           aw_idx, ar_idx, ld_addr;
    logic [AXI_DATA_WIDTH-1:0] ld_word;
    logic                      ld_inr, w_inr, w_over, cnt_at_len;
    logic                      w_hs, b_hs, r_hs;

    // Size/burst fields and sub-word address bits carry no information here.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                         s_axi_awaddr[OFF_W-1:0], s_axi_araddr[OFF_W-1:0]};

    function automatic logic in_range(input logic [WA_W-1:0] a);
        return (a >> MEM_DEPTH_LOG2) == '0;
    endfunction

    assign aw_idx     = s_axi_awaddr[AXI_ADDR_WIDTH-1:OFF_W];
    assign ar_idx     = s_axi_araddr[AXI_ADDR_WIDTH-1:OFF_W];
    // In IDLE the word being loaded is the AR target, otherwise the next beat.
    assign ld_addr    = (state == S_IDLE) ? ar_idx : addr_q + WA_ONE;
    assign ld_inr     = in_range(ld_addr);
    assign ld_word    = ld_inr ? mem[ld_addr[MEM_DEPTH_LOG2-1:0]] : '0;
    assign w_inr      = in_range(addr_q);
    assign cnt_at_len = (cnt_q == {1'b0, len_q});
    assign w_over     = (cnt_q > {1'b0, len_q});
    assign w_hs       = s_axi_wvalid && s_axi_wready;
    assign b_hs       = s_axi_bvalid && s_axi_bready;
    assign r_hs       = s_axi_rvalid && s_axi_rready;

    assign s_axi_bid   = id_q;
    assign s_axi_rid   = id_q;
    assign s_axi_rdata = rdata_q;
    assign s_axi_rresp = rresp_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_n       = state;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        busy          = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                s_axi_awready = s_axi_awvalid && (!s_axi_arvalid || !prio_rd);
                s_axi_arready = s_axi_arvalid && (!s_axi_awvalid || prio_rd);
                if (s_axi_awready) begin
                    state_n = S_WDATA;
                end else if (s_axi_arready) begin
`ifdef AXI_SLAVE_RSP_DELAY_EN
                    state_n = S_WAIT;
`else
                    state_n = S_RDATA;
`endif
                end
            end
            S_WDATA: begin
                s_axi_wready = 1'b1;
                if (w_hs && s_axi_wlast) begin
`ifdef AXI_SLAVE_RSP_DELAY_EN
                    state_n = S_WAIT;
`else
                    state_n = S_WRESP;
`endif
                end
            end
            S_WRESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (b_hs) state_n = S_IDLE;
            end
            S_RDATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = cnt_at_len;
                if (r_hs && cnt_at_len) state_n = S_IDLE;
            end
`ifdef AXI_SLAVE_RSP_DELAY_EN
            S_WAIT: begin
                if (dly_q == '0) state_n = dly_rd_q ? S_RDATA : S_WRESP;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // Transaction context, read-beat staging and arbitration priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_rd  <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
`ifdef AXI_SLAVE_RSP_DELAY_EN
            dly_q    <= '0;
            dly_rd_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_axi_awready) begin
                        id_q   <= s_axi_awid;
                        addr_q <= aw_idx;
                        len_q  <= s_axi_awlen;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                    end else if (s_axi_arready) begin
                        id_q    <= s_axi_arid;
                        addr_q  <= ar_idx;
                        len_q   <= s_axi_arlen;
                        cnt_q   <= '0;
                        rdata_q <= ld_word;
                        rresp_q <= ld_inr ? RESP_OKAY : RESP_SLVERR;
`ifdef AXI_SLAVE_RSP_DELAY_EN
                        dly_q    <= 8'(RSP_DELAY - 1);
                        dly_rd_q <= 1'b1;
`endif
                    end
                end
                S_WDATA: begin
                    if (w_hs) begin
                        // Excess beats freeze the counter at len+1 so w_over stays set.
                        if (!w_over) begin
                            addr_q <= addr_q + WA_ONE;
                            cnt_q  <= cnt_q + 9'd1;
                        end
                        if (!w_inr || w_over || (s_axi_wlast && !cnt_at_len))
                            err_q <= 1'b1;
`ifdef AXI_SLAVE_RSP_DELAY_EN
                        if (s_axi_wlast) begin
                            dly_q    <= 8'(RSP_DELAY - 1);
                            dly_rd_q <= 1'b0;
                        end
`endif
                    end
                end
                S_WRESP: begin
                    if (b_hs) prio_rd <= 1'b1;
                end
                S_RDATA: begin
                    if (r_hs) begin
                        if (cnt_at_len) begin
                            prio_rd <= 1'b0;
                        end else begin
                            addr_q  <= addr_q + WA_ONE;
                            cnt_q   <= cnt_q + 9'd1;
                            rdata_q <= ld_word;
                            rresp_q <= ld_inr ? RESP_OKAY : RESP_SLVERR;
                        end
                    end
                end
`ifdef AXI_SLAVE_RSP_DELAY_EN
                S_WAIT: begin
                    if (dly_q != '0) dly_q <= dly_q - 8'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Byte-strobed RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (state == S_WDATA && w_hs && !w_over && w_inr) begin
            for (int unsigned b = 0; b < AXI_STROBE_WIDTH; b++) begin
                if (s_axi_wstrb[b])
                    mem[addr_q[MEM_DEPTH_LOG2-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_vx_axi_mem_slave.sv
// Directed self-checking bench for vx_axi_mem_slave (64-bit data, 64-word RAM).
`timescale 1ns/1ps

module tb_vx_axi_mem_slave;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int SW = DW / 8;
    localparam int MD = 6;
    localparam int RSP_DELAY = 4;
`ifdef AXI_SLAVE_RSP_DELAY_EN
    localparam int EXP_LAT = 1 + RSP_DELAY;
`else
    localparam int EXP_LAT = 1;
`endif

    logic          clk, reset;
    logic [IW-1:0] s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0]    s_axi_awlen, s_axi_arlen;
    logic [2:0]    s_axi_awsize, s_axi_arsize;
    logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic          s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [DW-1:0] s_axi_wdata, s_axi_rdata;
    logic [SW-1:0] s_axi_wstrb;
    logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic          s_axi_rlast, s_axi_rvalid, s_axi_rready, busy;

    int checks = 0;
    int errors = 0;

    vx_axi_mem_slave #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .AXI_TID_WIDTH (IW),
        .MEM_DEPTH_LOG2(MD),
        .RSP_DELAY     (RSP_DELAY)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_wr;
        logic [7:0]  id;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  exp_resp;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
        #1;
        while (!s_axi_awready && n < 50) begin @(negedge clk); #1; n++; end
        check("aw_handshake", s_axi_awready, 1'b1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
        #1;
        while (!s_axi_arready && n < 50) begin @(negedge clk); #1; n++; end
        check("ar_handshake", s_axi_arready, 1'b1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input bit last);
        int n = 0;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        #1;
        while (!s_axi_wready && n < 50) begin @(negedge clk); #1; n++; end
        check("w_handshake", s_axi_wready, 1'b1);
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    // Called one step after the wlast handshake edge.
    task automatic wait_b(input logic [7:0] id, input logic [1:0] resp);
        int lat = 1;
        while (!s_axi_bvalid && lat < 60) begin @(posedge clk); #1; lat++; end
        check("b_latency", lat, EXP_LAT);
        check("bid", s_axi_bid, id);
        check("bresp", s_axi_bresp, resp);
        @(posedge clk); #1;
        check("b_hold_valid", s_axi_bvalid, 1'b1);
        check("b_hold_resp", s_axi_bresp, resp);
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        check("b_done_valid", s_axi_bvalid, 1'b0);
        check("b_done_busy", busy, 1'b0);
    endtask

    // Single-beat read response; called one step after the AR handshake edge.
    task automatic wait_r(input logic [7:0] id, input logic [63:0] data, input logic [1:0] resp);
        int lat = 1;
        while (!s_axi_rvalid && lat < 60) begin @(posedge clk); #1; lat++; end
        check("r_latency", lat, EXP_LAT);
        check("rid", s_axi_rid, id);
        check("rdata", s_axi_rdata, data);
        check("rresp", s_axi_rresp, resp);
        check("rlast", s_axi_rlast, 1'b1);
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
        check("r_done_valid", s_axi_rvalid, 1'b0);
        check("r_done_busy", busy, 1'b0);
    endtask

    // Reads the 4-beat burst at 0x100 (values 1..4), rready toggling or held high.
    task automatic read_burst(input bit toggle);
        int lat = 1;
        int beat = 0;
        int cyc = 0;
        bit rr = 1'b1;
        send_ar(8'h22, 32'h100, 8'd3);
        while (!s_axi_rvalid && lat < 60) begin @(posedge clk); #1; lat++; end
        check("burst_latency", lat, EXP_LAT);
        while (beat < 4 && cyc < 40) begin
            check("burst_rvalid", s_axi_rvalid, 1'b1);
            check("burst_rdata", s_axi_rdata, 64'(beat + 1));
            check("burst_rlast", s_axi_rlast, (beat == 3) ? 1'b1 : 1'b0);
            check("burst_rid", s_axi_rid, 8'h22);
            check("burst_rresp", s_axi_rresp, 2'd0);
            s_axi_rready = toggle ? rr : 1'b1;
            @(posedge clk); #1;
            if (s_axi_rready) beat++;
            rr = !rr;
            cyc++;
        end
        s_axi_rready = 1'b0;
        check("burst_beats", beat, 4);
        check("burst_cycles", cyc, toggle ? 7 : 4);
        check("burst_done_valid", s_axi_rvalid, 1'b0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b1, 8'h05, 32'h0000_0040, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 2'd0, 64'h0};
        vecs[1]  = '{1'b0, 8'h03, 32'h0000_0040, 64'h0, 8'h00, 2'd0, 64'hA5A5_A5A5_A5A5_A5A5};
        vecs[2]  = '{1'b1, 8'h01, 32'h0000_0080, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'd0, 64'h0};
        vecs[3]  = '{1'b1, 8'h02, 32'h0000_0080, 64'h0, 8'h0F, 2'd0, 64'h0};
        vecs[4]  = '{1'b0, 8'h04, 32'h0000_0080, 64'h0, 8'h00, 2'd0, 64'hFFFF_FFFF_0000_0000};
        vecs[5]  = '{1'b1, 8'h06, 32'h0000_0000, 64'h1122_3344_5566_7788, 8'hFF, 2'd0, 64'h0};
        vecs[6]  = '{1'b1, 8'h07, 32'h0000_0200, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 2'd2, 64'h0};
        vecs[7]  = '{1'b0, 8'h08, 32'h0000_0000, 64'h0, 8'h00, 2'd0, 64'h1122_3344_5566_7788};
        vecs[8]  = '{1'b0, 8'h09, 32'h0000_0200, 64'h0, 8'h00, 2'd2, 64'h0};
        vecs[9]  = '{1'b1, 8'h0A, 32'hFFFF_FFF8, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 2'd2, 64'h0};
        vecs[10] = '{1'b1, 8'h0B, 32'h0000_01F8, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'd0, 64'h0};
        vecs[11] = '{1'b0, 8'h0C, 32'h0000_01F8, 64'h0, 8'h00, 2'd0, 64'h0123_4567_89AB_CDEF};

        reset = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3;
        s_axi_awburst = 2'd1; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3;
        s_axi_arburst = 2'd1; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

        reset_dut();
        #1;
        check("rst_awready", s_axi_awready, 1'b0);
        check("rst_arready", s_axi_arready, 1'b0);
        check("rst_wready", s_axi_wready, 1'b0);
        check("rst_bvalid", s_axi_bvalid, 1'b0);
        check("rst_rvalid", s_axi_rvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_bid", s_axi_bid, 8'h0);
        check("rst_rid", s_axi_rid, 8'h0);
        check("rst_rdata", s_axi_rdata, 64'h0);
        check("rst_rlast", s_axi_rlast, 1'b0);
        check("rst_bresp", s_axi_bresp, 2'd0);
        check("rst_rresp", s_axi_rresp, 2'd0);

        // Single-beat vectors: basic write/read, strobes, range edges.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) begin
                send_aw(vecs[i].id, vecs[i].addr, 8'd0);
                check("busy_in_write", busy, 1'b1);
                send_w(vecs[i].data, vecs[i].strb, 1'b1);
                wait_b(vecs[i].id, vecs[i].exp_resp);
            end else begin
                send_ar(vecs[i].id, vecs[i].addr, 8'd0);
                wait_r(vecs[i].id, vecs[i].exp_data, vecs[i].exp_resp);
            end
        end

        // Four-beat burst write then reads with stalls and at full rate.
        send_aw(8'h21, 32'h100, 8'd3);
        for (int b = 0; b < 4; b++) send_w(64'(b + 1), 8'hFF, b == 3);
        wait_b(8'h21, 2'd0);
        read_burst(1'b1);
        read_burst(1'b0);

        // Early wlast on a two-beat burst.
        send_aw(8'h31, 32'h180, 8'd1);
        send_w(64'h1111, 8'hFF, 1'b1);
        wait_b(8'h31, 2'd2);
        // Extra beat past len: first beat kept, second dropped.
        send_aw(8'h32, 32'h188, 8'd0);
        send_w(64'hAAAA, 8'hFF, 1'b0);
        send_w(64'hBBBB, 8'hFF, 1'b1);
        wait_b(8'h32, 2'd2);
        send_ar(8'h33, 32'h188, 8'd0);
        wait_r(8'h33, 64'hAAAA, 2'd0);

        // Arbitration: write wins first tie after reset, read wins the next.
        reset_dut();
        s_axi_awid = 8'h0A; s_axi_awaddr = 32'h140; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
        s_axi_arid = 8'h0B; s_axi_araddr = 32'h40; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
        #1;
        check("tie1_awready", s_axi_awready, 1'b1);
        check("tie1_arready", s_axi_arready, 1'b0);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        check("ar_blocked", s_axi_arready, 1'b0);
        send_w(64'h5555, 8'hFF, 1'b1);
        wait_b(8'h0A, 2'd0);
        s_axi_awid = 8'h0C; s_axi_awaddr = 32'h148; s_axi_awvalid = 1'b1;
        #1;
        check("tie2_arready", s_axi_arready, 1'b1);
        check("tie2_awready", s_axi_awready, 1'b0);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        wait_r(8'h0B, 64'hA5A5_A5A5_A5A5_A5A5, 2'd0);
        send_aw(8'h0C, 32'h148, 8'd0);
        send_w(64'h6666, 8'hFF, 1'b1);
        wait_b(8'h0C, 2'd0);

        // Reset in the middle of a read burst.
        send_ar(8'h41, 32'h100, 8'd3);
        n = 0;
        while (!s_axi_rvalid && n < 60) begin @(posedge clk); #1; n++; end
        check("mid_rvalid", s_axi_rvalid, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_rvalid", s_axi_rvalid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rdata", s_axi_rdata, 64'h0);
        check("mid_rst_rlast", s_axi_rlast, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        send_ar(8'h42, 32'h108, 8'd0);
        wait_r(8'h42, 64'h2, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
